// File: rtl/router_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : router_tile_scheduler
// Description : Steps one input router and one weight router through a layer:
//               clear, enable, wait for ready, then lockstep pops per tile.
// Revision    : 1.0
// ============================================================================
module router_tile_scheduler #(
    parameter int TILE_W  = 8,
    parameter int POP_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [TILE_W-1:0] i_tile_count,
    input  logic              i_pe_ready,
    input  logic              i_ir_ready,
    input  logic              i_ir_context_done,
    input  logic              i_ir_output_done,
    input  logic              i_wr_ready,
    input  logic              i_wr_done,
    output logic              o_ir_en,
    output logic              o_wr_en,
    output logic              o_ir_reg_clear,
    output logic              o_wr_reg_clear,
    output logic              o_ir_pop_en,
    output logic              o_wr_pop_en,
    output logic [TILE_W-1:0] o_tile_idx,
    output logic [POP_W-1:0]  o_pop_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [2:0]        o_state
);

    localparam int            c_WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_LOAD       = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_STREAM     = 3'd4,
        ST_NEXT       = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERROR      = 3'd7
    } state_t;

    state_t              r_state;
    logic [TILE_W-1:0]   r_tile_count;
    logic [TILE_W-1:0]   r_tile_idx;
    logic [POP_W-1:0]    r_pop_count;
    logic [c_WD_W-1:0]   r_wd;
    logic                r_ir_seen;
    logic                r_wr_seen;
    logic                r_layer_end;

    logic                w_pop;
    logic                w_ir_ok;
    logic                w_wr_ok;
    logic                w_unused_wr_done;

    // The weight router is slaved to the input router, so its done is unused.
    assign w_unused_wr_done = i_wr_done;

    assign w_pop   = (r_state == ST_STREAM) && i_pe_ready;
    assign w_ir_ok = r_ir_seen || i_ir_ready;
    assign w_wr_ok = r_wr_seen || i_wr_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_tile_count <= '0;
            r_tile_idx   <= '0;
            r_pop_count  <= '0;
            r_wd         <= '0;
            r_ir_seen    <= 1'b0;
            r_wr_seen    <= 1'b0;
            r_layer_end  <= 1'b0;
        end else if (i_abort) begin
            r_state      <= ST_IDLE;
            r_tile_count <= '0;
            r_tile_idx   <= '0;
            r_pop_count  <= '0;
            r_wd         <= '0;
            r_ir_seen    <= 1'b0;
            r_wr_seen    <= 1'b0;
            r_layer_end  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_tile_count != '0) begin
                            r_tile_count <= i_tile_count;
                            r_tile_idx   <= '0;
                            r_layer_end  <= 1'b0;
                            r_state      <= ST_CLEAR;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_pop_count <= '0;
                    r_ir_seen   <= 1'b0;
                    r_wr_seen   <= 1'b0;
                    r_wd        <= '0;
                    r_state     <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_state <= ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    r_ir_seen <= w_ir_ok;
                    r_wr_seen <= w_wr_ok;
                    // A ready pair in the last watchdog cycle still wins.
                    if (w_ir_ok && w_wr_ok) begin
                        r_state <= ST_STREAM;
                    end else if (r_wd == c_WD_LAST) begin
                        r_state <= ST_ERROR;
                    end else begin
                        r_wd <= r_wd + c_WD_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (w_pop && !(&r_pop_count)) begin
                        r_pop_count <= r_pop_count + POP_W'(1);
                    end
                    if (i_ir_output_done) begin
                        r_layer_end <= 1'b1;
                    end
                    if (i_ir_context_done || i_ir_output_done) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if ((r_tile_idx == r_tile_count - TILE_W'(1)) || r_layer_end) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_tile_idx <= r_tile_idx + TILE_W'(1);
                        r_state    <= ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ir_en        = (r_state == ST_WAIT_READY) || (r_state == ST_STREAM);
    assign o_wr_en        = o_ir_en;
    assign o_ir_reg_clear = (r_state == ST_CLEAR);
    assign o_wr_reg_clear = (r_state == ST_CLEAR);
    assign o_ir_pop_en    = w_pop;
    assign o_wr_pop_en    = w_pop;
    assign o_tile_idx     = r_tile_idx;
    assign o_pop_count    = r_pop_count;
    assign o_busy         = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERROR);
    assign o_done         = (r_state == ST_DONE);
    assign o_error        = (r_state == ST_ERROR);
    assign o_state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_router_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_tile_scheduler
// Description : Directed scenarios plus randomized traffic against a
//               behavioural layer-sequencing model of router_tile_scheduler.
// Revision    : 1.0
// ============================================================================
module tb_router_tile_scheduler;

    localparam int TILE_W  = 8;
    localparam int POP_W   = 5;
    localparam int TIMEOUT = 16;
    localparam int POP_MAX = (1 << POP_W) - 1;

    logic              clk;
    logic              rst;
    logic              start, abort, pe_ready;
    logic [TILE_W-1:0] tile_count;
    logic              ir_ready, ir_ctx, ir_out, wr_ready, wr_done;
    logic              ir_en, wr_en, ir_clr, wr_clr, ir_pop, wr_pop;
    logic [TILE_W-1:0] tile_idx;
    logic [POP_W-1:0]  pop_count;
    logic              busy, done, error;
    logic [2:0]        state;

    int checks = 0;
    int errors = 0;
    int n_clear = 0;
    int n_done  = 0;
    int idx_q[$];

    router_tile_scheduler #(.TILE_W(TILE_W), .POP_W(POP_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_tile_count(tile_count), .i_pe_ready(pe_ready),
        .i_ir_ready(ir_ready), .i_ir_context_done(ir_ctx), .i_ir_output_done(ir_out),
        .i_wr_ready(wr_ready), .i_wr_done(wr_done),
        .o_ir_en(ir_en), .o_wr_en(wr_en), .o_ir_reg_clear(ir_clr), .o_wr_reg_clear(wr_clr),
        .o_ir_pop_en(ir_pop), .o_wr_pop_en(wr_pop), .o_tile_idx(tile_idx),
        .o_pop_count(pop_count), .o_busy(busy), .o_done(done), .o_error(error),
        .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase of the layer plus plain integer bookkeeping.
    int m_state, m_cnt, m_idx, m_pop, m_wd;
    bit m_ir_seen, m_wr_seen, m_end;

    always @(posedge clk or posedge rst) begin
        if (rst || abort) begin
            m_state <= 0; m_cnt <= 0; m_idx <= 0; m_pop <= 0; m_wd <= 0;
            m_ir_seen <= 0; m_wr_seen <= 0; m_end <= 0;
        end else begin
            if (m_state == 0 && start && tile_count != 0) begin
                m_cnt <= int'(tile_count); m_idx <= 0; m_end <= 0; m_state <= 1;
            end else if (m_state == 0 && start) begin
                m_state <= 6;
            end else if (m_state == 1) begin
                m_pop <= 0; m_ir_seen <= 0; m_wr_seen <= 0; m_wd <= 0; m_state <= 2;
            end else if (m_state == 2) begin
                m_state <= 3;
            end else if (m_state == 3) begin
                m_ir_seen <= m_ir_seen | ir_ready;
                m_wr_seen <= m_wr_seen | wr_ready;
                if ((m_ir_seen | ir_ready) && (m_wr_seen | wr_ready)) m_state <= 4;
                else if (m_wd + 1 >= TIMEOUT) m_state <= 7;
                else m_wd <= m_wd + 1;
            end else if (m_state == 4) begin
                if (pe_ready) m_pop <= (m_pop + 1 > POP_MAX) ? POP_MAX : m_pop + 1;
                if (ir_out) m_end <= 1;
                if (ir_ctx || ir_out) m_state <= 5;
            end else if (m_state == 5) begin
                if (m_idx + 1 == m_cnt || m_end) m_state <= 6;
                else begin m_idx <= m_idx + 1; m_state <= 1; end
            end else if (m_state == 6) begin
                m_state <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("state", state, m_state);
        chk("busy", busy, m_state >= 1 && m_state <= 5);
        chk("done", done, m_state == 6);
        chk("error", error, m_state == 7);
        chk("ir_en", ir_en, m_state == 3 || m_state == 4);
        chk("wr_en", wr_en, m_state == 3 || m_state == 4);
        chk("ir_clr", ir_clr, m_state == 1);
        chk("wr_clr", wr_clr, m_state == 1);
        chk("ir_pop", ir_pop, m_state == 4 && pe_ready);
        chk("wr_pop", wr_pop, m_state == 4 && pe_ready);
        chk("tile_idx", tile_idx, m_idx);
        chk("pop_count", pop_count, m_pop);
        if (ir_clr && wr_clr) begin
            n_clear++;
            idx_q.push_back(int'(tile_idx));
        end
        if (done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        start = 0; abort = 0; pe_ready = 0; tile_count = '0;
        ir_ready = 0; ir_ctx = 0; ir_out = 0; wr_ready = 0; wr_done = 0;
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        for (int i = 0; i < budget && int'(state) != s; i++) tick();
        chk(nm, state, s);
    endtask

    task automatic run_to_stream(input int cnt);
        start = 1; tile_count = TILE_W'(cnt);
        tick();
        start = 0; ir_ready = 1; wr_ready = 1;
        wait_state(4, 10, "reach_stream");
        ir_ready = 0; wr_ready = 0;
    endtask

    initial begin
        int n;
        int mode;
        clear_in();
        rst = 1;
        repeat (3) tick();
        chk("reset_state", state, 0);
        chk("reset_busy", busy, 0);
        rst = 0;
        tick();

        // Single tile with staggered readies.
        n_done = 0;
        start = 1; tile_count = 1;
        tick(); start = 0;
        chk("t1_clear", state, 1);
        tick(); chk("t1_load", state, 2);
        tick(); tick(); tick();
        ir_ready = 1; tick(); ir_ready = 0;
        tick(); tick();
        wr_ready = 1; tick(); wr_ready = 0;
        chk("t1_stream_entry", state, 4);
        pe_ready = 1; repeat (10) tick();
        pe_ready = 0; ir_ctx = 1; tick(); ir_ctx = 0;
        chk("t1_pop_count", pop_count, 10);
        tick();
        chk("t1_done", done, 1);
        chk("t1_idx", tile_idx, 0);
        tick();
        chk("t1_done_once", n_done, 1);

        // Backpressure: pops follow pe_ready within the cycle.
        run_to_stream(1);
        for (int i = 0; i < 8; i++) begin
            pe_ready = (i % 2 == 0);
            #1;
            chk("bp_pop_mirror", ir_pop, pe_ready);
            chk("bp_pop_equal", wr_pop, ir_pop);
            tick();
        end
        pe_ready = 0; ir_ctx = 1; tick(); ir_ctx = 0;
        chk("bp_pop_count", pop_count, 4);
        wait_state(0, 10, "bp_idle");

        // Three tiles.
        n_clear = 0; n_done = 0; idx_q.delete();
        start = 1; tile_count = 3; tick(); start = 0;
        for (int t = 0; t < 3; t++) begin
            ir_ready = 1; wr_ready = 1;
            wait_state(4, 10, "mt_stream");
            ir_ready = 0; wr_ready = 0;
            pe_ready = 1; repeat (3) tick();
            pe_ready = 0; ir_ctx = 1; tick(); ir_ctx = 0;
            if (t < 2) chk("mt_no_early_done", n_done, 0);
        end
        wait_state(0, 10, "mt_idle");
        chk("mt_clears", n_clear, 3);
        chk("mt_done", n_done, 1);
        chk("mt_idx_len", idx_q.size(), 3);
        for (int i = 0; i < 3 && i < idx_q.size(); i++) chk("mt_idx_seq", idx_q[i], i);

        // Layer ends early on output_done in tile 1.
        start = 1; tile_count = 5; tick(); start = 0;
        for (int t = 0; t < 2; t++) begin
            ir_ready = 1; wr_ready = 1;
            wait_state(4, 10, "ee_stream");
            ir_ready = 0; wr_ready = 0;
            pe_ready = 1; tick(); pe_ready = 0;
            if (t == 1) ir_out = 1; else ir_ctx = 1;
            tick(); ir_out = 0; ir_ctx = 0;
        end
        chk("ee_next", state, 5);
        tick();
        chk("ee_done", state, 6);
        chk("ee_idx", tile_idx, 1);
        tick();

        // Watchdog, ignored start in ERROR, abort recovery.
        start = 1; tile_count = 1; tick(); start = 0; ir_ready = 1;
        wait_state(3, 5, "wd_wait");
        n = 0;
        while (state == 3'd3 && n < 100) begin tick(); n++; end
        chk("wd_cycles", n, 16);
        chk("wd_error", error, 1);
        chk("wd_en_off", ir_en, 0);
        ir_ready = 0;
        start = 1; tile_count = 2; tick(); start = 0;
        chk("wd_start_ignored", state, 7);
        abort = 1; tick(); abort = 0;
        chk("wd_abort_idle", state, 0);
        chk("wd_abort_error", error, 0);

        // Zero tiles.
        n_clear = 0;
        start = 1; tile_count = 0; tick(); start = 0;
        chk("z_done", done, 1);
        chk("z_no_en", ir_en, 0);
        tick();
        chk("z_no_clear", n_clear, 0);

        // Asynchronous reset while streaming.
        run_to_stream(2);
        pe_ready = 1;
        @(posedge clk); #3;
        rst = 1; #1;
        chk("ar_pop_drop", ir_pop, 0);
        chk("ar_busy_drop", busy, 0);
        chk("ar_state", state, 0);
        @(posedge clk); #1;
        rst = 0; pe_ready = 0;
        tick();

        // Randomized traffic.
        mode = 0;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            if (cyc % 300 == 0) mode = int'($urandom_range(0, 3));
            start      = ($urandom_range(0, 15) == 0);
            tile_count = TILE_W'($urandom_range(0, 4));
            abort      = ($urandom_range(0, 199) == 0);
            pe_ready   = ($urandom_range(0, 2) != 0);
            ir_ready   = ($urandom_range(0, (mode == 1) ? 11 : 2) == 0);
            wr_ready   = (mode != 2) && ($urandom_range(0, (mode == 1) ? 11 : 2) == 0);
            ir_ctx     = ($urandom_range(0, (mode == 3) ? 79 : 9) == 0);
            ir_out     = ($urandom_range(0, (mode == 3) ? 199 : 39) == 0);
            wr_done    = ($urandom_range(0, 3) == 0);
            tick();
        end
        clear_in();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
